// File: rtl/req_ack_mon_pkg.sv
// Shared types and constants for the req/ack liveness monitor.
package req_ack_mon_pkg;

   // Per-channel monitor state: idle, or waiting for the acknowledge of an accepted request.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mon_state_e;

   // Bit positions inside the packed per-channel error vector.
   localparam int ERR_W      = 5;
   localparam int TIMEOUT    = 0;
   localparam int EARLY      = 1;
   localparam int SPURIOUS   = 2;
   localparam int OVERLAP    = 3;
   localparam int UNRESOLVED = 4;

endpackage

// File: rtl/req_ack_chan.sv
// One monitored req/ack channel: edge detect, IDLE/WAIT tracker, latency
// counter, held latency of the last pass and one-cycle event pulses.
module req_ack_chan
   import req_ack_mon_pkg::*;
#(
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 16,
   parameter int LAT_W   = 16
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic             i_ack,
   input  logic             i_eot,
   output logic             o_pending,
   output logic             o_pass,
   output logic [LAT_W-1:0] o_lat,
   output logic [ERR_W-1:0] o_err
);

   localparam logic [LAT_W-1:0] MIN_K   = LAT_W'(MIN_LAT);
   localparam logic [LAT_W-1:0] MAX_K   = LAT_W'(MAX_LAT);
   localparam bit               BOUNDED = (MAX_LAT != 0);

   mon_state_e       r_state;
   logic             r_req_q;
   logic             r_ack_q;
   logic [LAT_W-1:0] r_cnt;
   logic [LAT_W-1:0] r_lat;
   logic             r_pass;
   logic [ERR_W-1:0] r_err;

   logic             w_req_rise;
   logic             w_ack_rise;
   logic [LAT_W-1:0] w_k;

   assign w_req_rise = i_req & ~r_req_q;
   assign w_ack_rise = i_ack & ~r_ack_q;
   assign w_k        = r_cnt + LAT_W'(1);

   // Track one outstanding request; resolve it by pass, early, timeout or end-of-test.
   always_ff @(posedge i_clk) begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // below sees the values from before this edge, not partially updated ones.
      if (i_rst) begin
         r_state <= IDLE;
         r_req_q <= 1'b0;
         r_ack_q <= 1'b0;
         r_cnt   <= '0;
         r_lat   <= '0;
         r_pass  <= 1'b0;
         r_err   <= '0;
      end else begin
         r_req_q <= i_req;
         r_ack_q <= i_ack;
         r_pass  <= 1'b0;
         r_err   <= '0;
         case (r_state)
            IDLE: begin
               // A same-edge ack never satisfies the request that starts here.
               if (w_req_rise) begin
                  r_state <= WAIT;
                  r_cnt   <= '0;
               end else if (w_ack_rise) begin
                  r_err[SPURIOUS] <= 1'b1;
               end
            end
            WAIT: begin
               r_cnt <= w_k;
               if (i_eot) begin
                  r_err[UNRESOLVED] <= 1'b1;
                  r_state           <= IDLE;
               end else if (w_ack_rise) begin
                  if (w_k >= MIN_K) begin
                     r_pass <= 1'b1;
                     r_lat  <= w_k;
                  end else begin
                     r_err[EARLY] <= 1'b1;
                  end
                  r_state <= IDLE;
               end else if (BOUNDED && (w_k == MAX_K)) begin
                  r_err[TIMEOUT] <= 1'b1;
                  r_state        <= IDLE;
               end else if (w_req_rise) begin
                  // The original request keeps counting; the new rise is not queued.
                  r_err[OVERLAP] <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_pending = (r_state == WAIT);
   assign o_pass    = r_pass;
   assign o_lat     = r_lat;
   assign o_err     = r_err;

endmodule

// File: rtl/req_ack_mon.sv
// Multi-channel req/ack liveness monitor: NUM_CH independent channel
// trackers plus saturating totals of passes and error pulses.
module req_ack_mon
   import req_ack_mon_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 16,
   parameter int LAT_W   = 16,
   parameter int CNT_W   = 16
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NUM_CH-1:0]       i_req,
   input  logic [NUM_CH-1:0]       i_ack,
   input  logic                    i_eot,
   output logic [NUM_CH-1:0]       o_pending,
   output logic [NUM_CH-1:0]       o_pass,
   output logic [NUM_CH*LAT_W-1:0] o_lat,
   output logic [NUM_CH-1:0]       o_err_timeout,
   output logic [NUM_CH-1:0]       o_err_early,
   output logic [NUM_CH-1:0]       o_err_spurious,
   output logic [NUM_CH-1:0]       o_err_overlap,
   output logic [NUM_CH-1:0]       o_err_unresolved,
   output logic [CNT_W-1:0]        o_pass_cnt,
   output logic [CNT_W-1:0]        o_fail_cnt
);

   // Headroom above the counter width so the add cannot wrap before the clamp.
   localparam int               SUM_W   = CNT_W + 8;
   localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

   logic [ERR_W-1:0] w_err [NUM_CH];
   logic [7:0]       w_pass_inc;
   logic [7:0]       w_fail_inc;
   logic [SUM_W-1:0] w_pass_sum;
   logic [SUM_W-1:0] w_fail_sum;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
      req_ack_chan #(
         .MIN_LAT (MIN_LAT),
         .MAX_LAT (MAX_LAT),
         .LAT_W   (LAT_W)
      ) u_chan (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_req     (i_req[g]),
         .i_ack     (i_ack[g]),
         .i_eot     (i_eot),
         .o_pending (o_pending[g]),
         .o_pass    (o_pass[g]),
         .o_lat     (o_lat[g*LAT_W +: LAT_W]),
         .o_err     (w_err[g])
      );

      assign o_err_timeout[g]    = w_err[g][TIMEOUT];
      assign o_err_early[g]      = w_err[g][EARLY];
      assign o_err_spurious[g]   = w_err[g][SPURIOUS];
      assign o_err_overlap[g]    = w_err[g][OVERLAP];
      assign o_err_unresolved[g] = w_err[g][UNRESOLVED];
   end

   // Population count of this cycle's pass and error pulses across all channels.
   always_comb begin
      // NOTE: both sums get a value before the loops so no path leaves them
      // unassigned, which would otherwise infer a latch.
      w_pass_inc = '0;
      w_fail_inc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pass_inc = w_pass_inc + 8'(o_pass[i]);
         for (int j = 0; j < ERR_W; j++) begin
            w_fail_inc = w_fail_inc + 8'(w_err[i][j]);
         end
      end
   end

   assign w_pass_sum = SUM_W'(r_pass_cnt) + SUM_W'(w_pass_inc);
   assign w_fail_sum = SUM_W'(r_fail_cnt) + SUM_W'(w_fail_inc);

   // Saturating totals; they trail the pulses they count by one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pass_cnt <= '0;
         r_fail_cnt <= '0;
      end else begin
         r_pass_cnt <= (w_pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
         r_fail_cnt <= (w_fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
      end
   end

   assign o_pass_cnt = r_pass_cnt;
   assign o_fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_req_ack_mon.sv
// Bench for req_ack_mon: two instances (bounded window with wide counters,
// unbounded window with 2-bit counters) share one stimulus stream. A
// timestamp-based reference model queues the expected outputs per edge and
// a monitor pops and compares them shortly after each rising edge.
module tb_req_ack_mon;

   localparam int NCH   = 2;
   localparam int MIN_L = 2;
   localparam int LW    = 16;

   typedef struct packed {
      logic [1:0]  pending;
      logic [1:0]  pass;
      logic [31:0] lat;
      logic [9:0]  err;   // {timeout, early, spurious, overlap, unresolved}, 2 bits each
      logic [15:0] pcnt;
      logic [15:0] fcnt;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = '0;
   logic [1:0] ack = '0;
   logic       eot = 1'b0;

   always #5 clk = ~clk;

   logic [1:0]  a_pending, a_pass, a_to, a_early, a_spur, a_ovl, a_unres;
   logic [31:0] a_lat;
   logic [15:0] a_pcnt, a_fcnt;
   logic [1:0]  b_pending, b_pass, b_to, b_early, b_spur, b_ovl, b_unres;
   logic [31:0] b_lat;
   logic [1:0]  b_pcnt, b_fcnt;

   req_ack_mon #(.NUM_CH(NCH), .MIN_LAT(MIN_L), .MAX_LAT(8), .LAT_W(LW), .CNT_W(16)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack), .i_eot(eot),
      .o_pending(a_pending), .o_pass(a_pass), .o_lat(a_lat),
      .o_err_timeout(a_to), .o_err_early(a_early), .o_err_spurious(a_spur),
      .o_err_overlap(a_ovl), .o_err_unresolved(a_unres),
      .o_pass_cnt(a_pcnt), .o_fail_cnt(a_fcnt)
   );

   req_ack_mon #(.NUM_CH(NCH), .MIN_LAT(MIN_L), .MAX_LAT(0), .LAT_W(LW), .CNT_W(2)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack), .i_eot(eot),
      .o_pending(b_pending), .o_pass(b_pass), .o_lat(b_lat),
      .o_err_timeout(b_to), .o_err_early(b_early), .o_err_spurious(b_spur),
      .o_err_overlap(b_ovl), .o_err_unresolved(b_unres),
      .o_pass_cnt(b_pcnt), .o_fail_cnt(b_fcnt)
   );

   // ---------------- reference model (timestamps, not counters) ----------------
   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_a_q[$];
   obs_t exp_b_q[$];

   int         m_t = 0;
   int         m_start [2][2];   // edge index of the accepted req rise, -1 when idle
   int         m_lat   [2][2];
   int         m_pcnt  [2];
   int         m_fcnt  [2];
   int         m_np    [2];      // passes reported on the previous edge
   int         m_nf    [2];      // errors reported on the previous edge
   logic [1:0] m_preq = '0;
   logic [1:0] m_pack = '0;
   int         max_lat_cfg [2] = '{8, 0};
   int         cnt_max_cfg [2] = '{65535, 3};

   task automatic model_edge(input logic [1:0] rq, input logic [1:0] ak, input logic e, input logic r);
      obs_t       o [2];
      logic [1:0] rr;
      logic [1:0] ar;
      rr = rq & ~m_preq;
      ar = ak & ~m_pack;
      for (int d = 0; d < 2; d++) begin
         o[d] = '0;
         if (r) begin
            for (int c = 0; c < NCH; c++) begin
               m_start[d][c] = -1;
               m_lat[d][c]   = 0;
            end
            m_pcnt[d] = 0;
            m_fcnt[d] = 0;
            m_np[d]   = 0;
            m_nf[d]   = 0;
         end else begin
            m_pcnt[d] = (m_pcnt[d] + m_np[d] > cnt_max_cfg[d]) ? cnt_max_cfg[d] : m_pcnt[d] + m_np[d];
            m_fcnt[d] = (m_fcnt[d] + m_nf[d] > cnt_max_cfg[d]) ? cnt_max_cfg[d] : m_fcnt[d] + m_nf[d];
            m_np[d] = 0;
            m_nf[d] = 0;
            for (int c = 0; c < NCH; c++) begin
               bit to = 0, ea = 0, sp = 0, ov = 0, un = 0, ps = 0;
               int k;
               if (m_start[d][c] < 0) begin
                  if (rr[c]) m_start[d][c] = m_t;
                  else if (ar[c]) sp = 1;
               end else begin
                  k = m_t - m_start[d][c];
                  if (e) un = 1;
                  else if (ar[c]) begin
                     if (k >= MIN_L) begin
                        ps = 1;
                        m_lat[d][c] = k;
                     end else ea = 1;
                  end
                  else if (max_lat_cfg[d] != 0 && k == max_lat_cfg[d]) to = 1;
                  else if (rr[c]) ov = 1;
                  if (un || ps || ea || to) m_start[d][c] = -1;
               end
               o[d].pass[c]  = ps;
               o[d].err[8+c] = to;
               o[d].err[6+c] = ea;
               o[d].err[4+c] = sp;
               o[d].err[2+c] = ov;
               o[d].err[c]   = un;
               m_np[d] += int'(ps);
               m_nf[d] += int'(to) + int'(ea) + int'(sp) + int'(ov) + int'(un);
            end
            for (int c = 0; c < NCH; c++) begin
               o[d].pending[c]        = (m_start[d][c] >= 0);
               o[d].lat[c*LW +: LW]   = LW'(m_lat[d][c]);
            end
            o[d].pcnt = 16'(m_pcnt[d]);
            o[d].fcnt = 16'(m_fcnt[d]);
         end
      end
      m_preq = r ? 2'b00 : rq;
      m_pack = r ? 2'b00 : ak;
      m_t++;
      exp_a_q.push_back(o[0]);
      exp_b_q.push_back(o[1]);
   endtask

   // Apply one cycle of inputs away from the rising edge and queue its expectation.
   task automatic drive(input logic [1:0] rq, input logic [1:0] ak, input logic e, input logic r);
      @(negedge clk);
      req = rq;
      ack = ak;
      eot = e;
      rst = r;
      model_edge(rq, ak, e, r);
   endtask

   task automatic do_reset();
      drive(2'b00, 2'b00, 1'b0, 1'b1);
      drive(2'b00, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(2'b00, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- monitor: pop and compare after every rising edge ----------------
   initial begin
      obs_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            check("A.pending", 64'(a_pending), 64'(e.pending));
            check("A.pass",    64'(a_pass),    64'(e.pass));
            check("A.lat",     64'(a_lat),     64'(e.lat));
            check("A.err",     64'({a_to, a_early, a_spur, a_ovl, a_unres}), 64'(e.err));
            check("A.pass_cnt", 64'(a_pcnt),   64'(e.pcnt));
            check("A.fail_cnt", 64'(a_fcnt),   64'(e.fcnt));
         end
         if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            check("B.pending", 64'(b_pending), 64'(e.pending));
            check("B.pass",    64'(b_pass),    64'(e.pass));
            check("B.lat",     64'(b_lat),     64'(e.lat));
            check("B.err",     64'({b_to, b_early, b_spur, b_ovl, b_unres}), 64'(e.err));
            check("B.pass_cnt", 64'(b_pcnt),   64'(e.pcnt));
            check("B.fail_cnt", 64'(b_fcnt),   64'(e.fcnt));
         end
      end
   end

   // Hard stop if the stimulus ever stalls.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time budget, got running expected finished");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] nr;
      logic [1:0] na;

      // Pass with latency 3.
      do_reset();
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b01, 1'b0, 1'b0);
      idle(3);

      // Timeout on the bounded instance; still pending on the unbounded one.
      do_reset();
      repeat (11) drive(2'b01, 2'b00, 1'b0, 1'b0);
      idle(2);

      // Early ack, then a spurious ack on the idle channel 1.
      do_reset();
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b01, 1'b0, 1'b0);
      idle(1);
      drive(2'b00, 2'b10, 1'b0, 1'b0);
      idle(2);

      // Overlapping request followed by a pass with latency 4.
      do_reset();
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b00, 2'b00, 1'b0, 1'b0);
      drive(2'b00, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b01, 1'b0, 1'b0);
      idle(2);

      // Long wait resolved by end-of-test, then a reset in the middle of a wait.
      do_reset();
      repeat (13) drive(2'b10, 2'b00, 1'b0, 1'b0);
      drive(2'b10, 2'b00, 1'b1, 1'b0);
      idle(1);
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b00, 1'b0, 1'b0);
      drive(2'b01, 2'b00, 1'b0, 1'b1);
      idle(10);

      // Both channels pass on the same edge, five times: 2-bit totals saturate.
      do_reset();
      repeat (5) begin
         drive(2'b11, 2'b00, 1'b0, 1'b0);
         drive(2'b11, 2'b00, 1'b0, 1'b0);
         drive(2'b11, 2'b11, 1'b0, 1'b0);
         drive(2'b00, 2'b00, 1'b0, 1'b0);
      end
      idle(2);

      // Randomized traffic with occasional end-of-test and reset.
      do_reset();
      nr = '0;
      na = '0;
      repeat (3000) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 3) == 0) nr[c] = ~nr[c];
            if ($urandom_range(0, 4) == 0) na[c] = ~na[c];
         end
         drive(nr, na, ($urandom_range(0, 79) == 0), ($urandom_range(0, 299) == 0));
      end
      idle(3);

      @(posedge clk);
      #2;
      check("queue_drain_a", 64'(exp_a_q.size()), 64'd0);
      check("queue_drain_b", 64'(exp_b_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/req_ack_mon.md
# req_ack_mon

Synthesizable multi-channel request/acknowledge liveness monitor. Per channel it checks that every rising edge of `req` is followed by a rising edge of `ack` within a latency window [MIN_LAT, MAX_LAT] cycles. It reports pass, timeout, early, spurious, overlap and unresolved-at-end-of-test events, plus saturating pass/fail counters. It sits beside any handshake interface in simulation benches or as an on-chip protocol checker, and replaces ad-hoc concurrent assertions of the `$rose(req) |-> strong(##[1:$] $rose(ack))` form.

## Interface
- `NUM_CH`, 4: number of independent req/ack channels (1..32).
- `MIN_LAT`, 1: minimum legal req-rise to ack-rise distance in cycles (≥1).
- `MAX_LAT`, 16: maximum legal distance; 0 means unbounded (liveness checked only at `eot`).
- `LAT_W`, 16: latency counter width; must hold MAX_LAT.
- `CNT_W`, 16: pass/fail counter width.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_CH: per-channel request level.
- `ack` in NUM_CH: per-channel acknowledge level.
- `eot` in 1: end-of-test strobe; resolves all pending requests as failures.
- `pending` out NUM_CH: channel waiting for ack.
- `pass` out NUM_CH: 1-cycle pulse, legal ack seen.
- `lat` out NUM_CH*LAT_W: latency of the last pass per channel, held until next pass.
- `err_timeout` out NUM_CH: 1-cycle pulse.
- `err_early` out NUM_CH: 1-cycle pulse.
- `err_spurious` out NUM_CH: 1-cycle pulse.
- `err_overlap` out NUM_CH: 1-cycle pulse.
- `err_unresolved` out NUM_CH: 1-cycle pulse.
- `pass_cnt` out CNT_W: total passes, all channels, saturating.
- `fail_cnt` out CNT_W: total error pulses, all channels, saturating.

## Operation
- Edge detect: `req_q`/`ack_q` hold the previous sample; rise = cur & ~prev. Reset clears `req_q`/`ack_q` to 0, so a level already high at the first post-reset edge counts as a rise.
- Per-channel FSM states are IDLE and WAIT, with counter `cnt`.
- IDLE, req rise: go to WAIT, cnt=0. A simultaneous ack rise is ignored; same-cycle acks never satisfy a request.
- IDLE, ack rise without req rise: `err_spurious`.
- WAIT, each edge: cnt+1, giving k = cnt+1.
- WAIT, ack rise with k ≥ MIN_LAT: `pass`, `lat`=k, go to IDLE.
- WAIT, ack rise with k < MIN_LAT: `err_early`, go to IDLE.
- WAIT, no ack rise and MAX_LAT≠0 and k = MAX_LAT: `err_timeout`, go to IDLE. An ack rise at exactly k = MAX_LAT passes.
- WAIT, req rise: `err_overlap`. The original request keeps its count; the new rise is not queued. Same-edge ack and timeout rules still apply.
- If the overlap req rise coincides with a pass/early/timeout, only the resolving event is reported and the channel goes to IDLE; the new rise is dropped.
- `eot` high: every WAIT channel pulses `err_unresolved` and goes to IDLE. This takes precedence over pass/timeout on the same edge. IDLE channels are unaffected.
- Counters: `pass_cnt` += popcount(`pass`); `fail_cnt` += popcount of all err pulses. Both saturate at 2^CNT_W−1.
- Reset: FSM→IDLE, cnt=0, all pulses 0, `pending`=0, `lat`=0, counters 0. Reset mid-WAIT discards the request silently.

## Timing
- All outputs are registered. An event sampled at posedge n appears on outputs after posedge n and is held for exactly one cycle (pulses).
- `pending` rises after the req-rise edge and falls after the resolving edge.
- Channels are fully independent; there is no arbitration.
- Counter update lands one cycle after the corresponding pulse.

## Structure
- Package `req_ack_mon_pkg`: state enum `mon_state_e {IDLE, WAIT}`; localparam error-index constants (TIMEOUT, EARLY, SPURIOUS, OVERLAP, UNRESOLVED) used to pack a per-channel error vector.
- Sub-module `req_ack_chan`: one channel's edge detect, FSM, cnt, `lat` register and pulses. Instantiated NUM_CH times via generate.
- Top level holds the popcount adders and saturating counters.

## Test plan
Config: NUM_CH=2, MIN_LAT=2, MAX_LAT=8.
- req0 rises at edge 1, ack0 rises at edge 4 -> `pass[0]` pulse, `lat[0]`=3, `pass_cnt`=1.
- req0 rises at edge 1, ack0 never rises -> `err_timeout[0]` at edge 9, `pending[0]` low afterwards, `fail_cnt`=1.
- req0 rises at edge 1, ack0 rises at edge 2 -> `err_early[0]`. Separately: ack1 rises with channel 1 IDLE -> `err_spurious[1]`.
- req0 rises at edge 1, req0 falls and rises again at edge 4, ack0 rises at edge 5 -> `err_overlap[0]` at edge 4, `pass[0]` with `lat`=4 at edge 5.
- MAX_LAT=0: req1 rises at edge 1, `eot` at edge 50 -> `err_unresolved[1]` at edge 50. Also: `rst` asserted at edge 5 during a WAIT -> no pulses, counters 0.
- Both channels pass on the same edge -> `pass_cnt` increments by 2. With CNT_W=2 and 5 passes -> `pass_cnt` stays at 3.
